// File: rtl/fetch_unit_pkg.sv
// Shared types for the fetch stage: machine word type and the fetch FSM encoding.
package cpu_types_pkg;
    typedef logic [31:0] word_t;

    localparam word_t WORD_BYTES = 32'd4;

    function automatic word_t next_word(input word_t addr);
        return addr + WORD_BYTES;
    endfunction
endpackage

package dp_types_pkg;
    typedef enum logic {
        FETCH  = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;
endpackage

// File: rtl/fetch_unit_if.sv
// Signal bundle for fetch_unit; fu is the stage's view, tb drives the other side.
interface fetch_unit_if
    import cpu_types_pkg::*;
(
    input logic CLK
);
    logic  RST;
    logic  ihit;
    word_t imemload;
    logic  imemREN;
    word_t imemaddr;
    logic  stall;
    logic  flush;
    logic  redirect;
    word_t redirect_pc;
    logic  halt_in;
    logic  ifid_valid;
    word_t ifid_instr;
    word_t ifid_pc;
    word_t ifid_npc;
    logic  halted;
    word_t fetch_count;

    modport fu (
        input  CLK, RST, ihit, imemload, stall, flush, redirect, redirect_pc, halt_in,
        output imemREN, imemaddr, ifid_valid, ifid_instr, ifid_pc, ifid_npc, halted, fetch_count
    );

    modport tb (
        input  CLK, imemREN, imemaddr, ifid_valid, ifid_instr, ifid_pc, ifid_npc, halted, fetch_count,
        output RST, ihit, imemload, stall, flush, redirect, redirect_pc, halt_in
    );
endinterface

// File: rtl/fetch_unit_ifid.sv
// IF/ID pipeline latch: load on en, drop valid on clr, payload held when invalidated.
module ifid_latch
    import cpu_types_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  en,
    input  logic  clr,
    input  word_t instr_in,
    input  word_t pc_in,
    input  word_t npc_in,
    output logic  valid,
    output word_t instr,
    output word_t pc,
    output word_t npc
);
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            instr <= '0;
            pc    <= '0;
            npc   <= '0;
        end else if (en) begin
            valid <= 1'b1;
            instr <= instr_in;
            pc    <= pc_in;
            npc   <= npc_in;
        end else if (clr) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, imem request, IF/ID latch and retired-fetch counter.
module fetch_unit
    import cpu_types_pkg::*;
    import dp_types_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000
) (
    input  logic  CLK,
    input  logic  RST,
    input  logic  ihit,
    input  word_t imemload,
    output logic  imemREN,
    output word_t imemaddr,
    input  logic  stall,
    input  logic  flush,
    input  logic  redirect,
    input  word_t redirect_pc,
    input  logic  halt_in,
    output logic  ifid_valid,
    output word_t ifid_instr,
    output word_t ifid_pc,
    output word_t ifid_npc,
    output logic  halted,
    output word_t fetch_count
);
    fetch_state_t state, state_next;
    word_t pc;
    word_t pc_plus4;
    logic  take_halt;
    logic  lat_en, lat_clr;
    logic  pc_load, pc_inc, cnt_inc;

    assign pc_plus4  = next_word(pc);
    assign imemaddr  = pc;
    // HALT is only honoured for a word that is not being squashed this cycle.
    assign take_halt = halt_in & ifid_valid & ~flush & ~redirect;

    always_ff @(posedge CLK) begin
        if (RST) state <= FETCH;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (state == FETCH && take_halt) state_next = HALTED;
    end

    always_comb begin
        imemREN = ~RST & (state == FETCH) & ~stall & ~redirect;
        halted  = (state == HALTED);
        lat_en  = 1'b0;
        lat_clr = 1'b0;
        pc_load = 1'b0;
        pc_inc  = 1'b0;
        cnt_inc = 1'b0;
        if (state == FETCH && !take_halt) begin
            if (redirect) begin
                pc_load = 1'b1;
                lat_clr = 1'b1;
            end else if (flush) begin
                lat_clr = 1'b1;
            end else if (stall) begin
                lat_clr = 1'b0;
            end else if (ihit) begin
                lat_en  = 1'b1;
                pc_inc  = 1'b1;
                cnt_inc = 1'b1;
            end else begin
                lat_clr = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST)          pc <= PC_INIT;
        else if (pc_load) pc <= redirect_pc & 32'hFFFF_FFFC;
        else if (pc_inc)  pc <= pc_plus4;
    end

    always_ff @(posedge CLK) begin
        if (RST)          fetch_count <= '0;
        else if (cnt_inc) fetch_count <= fetch_count + 32'd1;
    end

    ifid_latch u_ifid (
        .clk      (CLK),
        .rst      (RST),
        .en       (lat_en),
        .clr      (lat_clr),
        .instr_in (imemload),
        .pc_in    (pc),
        .npc_in   (pc_plus4),
        .valid    (ifid_valid),
        .instr    (ifid_instr),
        .pc       (ifid_pc),
        .npc      (ifid_npc)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: expected IF/ID words queued by stimulus, popped by a monitor.
module tb_fetch_unit;
    import cpu_types_pkg::*;

    typedef struct packed {
        word_t instr;
        word_t pc;
        word_t npc;
    } ifid_exp_t;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    fetch_unit_if fif (.CLK(CLK));

    fetch_unit #(.PC_INIT(32'h0000_0000)) dut (
        .CLK         (fif.CLK),
        .RST         (fif.RST),
        .ihit        (fif.ihit),
        .imemload    (fif.imemload),
        .imemREN     (fif.imemREN),
        .imemaddr    (fif.imemaddr),
        .stall       (fif.stall),
        .flush       (fif.flush),
        .redirect    (fif.redirect),
        .redirect_pc (fif.redirect_pc),
        .halt_in     (fif.halt_in),
        .ifid_valid  (fif.ifid_valid),
        .ifid_instr  (fif.ifid_instr),
        .ifid_pc     (fif.ifid_pc),
        .ifid_npc    (fif.ifid_npc),
        .halted      (fif.halted),
        .fetch_count (fif.fetch_count)
    );

    int checks = 0;
    int errors = 0;
    ifid_exp_t exp_q[$];
    word_t last_count = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // A newly latched instruction shows up as valid IF/ID with an advanced counter.
    always @(negedge CLK) begin
        if (fif.ifid_valid === 1'b1 && fif.fetch_count != last_count) begin
            ifid_exp_t e, got;
            got = '{fif.ifid_instr, fif.ifid_pc, fif.ifid_npc};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL ifid_unexpected actual=%h required=none", got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL ifid_word actual=%h required=%h", got, e);
                end
            end
        end
        last_count = fif.fetch_count;
    end

    initial begin
        #20000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        fif.RST = 1'b1; fif.ihit = 1'b0; fif.imemload = '0;
        fif.stall = 1'b0; fif.flush = 1'b0; fif.redirect = 1'b0;
        fif.redirect_pc = '0; fif.halt_in = 1'b0;
        #1;
        chk("ren_in_reset", {31'd0, fif.imemREN}, 32'd0);
        step();
        chk("rst_addr", fif.imemaddr, 32'h0);
        chk("rst_valid", {31'd0, fif.ifid_valid}, 32'd0);
        chk("rst_instr", fif.ifid_instr, 32'h0);
        chk("rst_halted", {31'd0, fif.halted}, 32'd0);
        chk("rst_count", fif.fetch_count, 32'd0);
        chk("rst_ren_held", {31'd0, fif.imemREN}, 32'd0);
        fif.RST = 1'b0;
        #1;
        chk("ren_after_rst", {31'd0, fif.imemREN}, 32'd1);

        // two back-to-back fetches
        fif.ihit = 1'b1; fif.imemload = 32'h2001_0005;
        exp_q.push_back('{32'h2001_0005, 32'h0, 32'h4});
        step();
        chk("addr_after_f1", fif.imemaddr, 32'h4);
        fif.imemload = 32'h2002_0003;
        exp_q.push_back('{32'h2002_0003, 32'h4, 32'h8});
        step();
        chk("addr_after_f2", fif.imemaddr, 32'h8);
        chk("count_after_f2", fif.fetch_count, 32'd2);

        // imem miss for three cycles
        fif.ihit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("miss_addr", fif.imemaddr, 32'h8);
            chk("miss_valid", {31'd0, fif.ifid_valid}, 32'd0);
            chk("miss_count", fif.fetch_count, 32'd2);
        end
        chk("miss_instr_held", fif.ifid_instr, 32'h2002_0003);

        // stall with ihit
        fif.stall = 1'b1; fif.ihit = 1'b1; fif.imemload = 32'hDEAD_BEEF;
        #1;
        chk("stall_ren", {31'd0, fif.imemREN}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("stall_addr", fif.imemaddr, 32'h8);
            chk("stall_count", fif.fetch_count, 32'd2);
            chk("stall_pc_held", fif.ifid_pc, 32'h4);
        end
        fif.stall = 1'b0; fif.imemload = 32'h8C01_0000;
        exp_q.push_back('{32'h8C01_0000, 32'h8, 32'hC});
        step();
        chk("resume_addr", fif.imemaddr, 32'hC);
        chk("resume_count", fif.fetch_count, 32'd3);

        // redirect beats stall and ihit; low bits dropped
        fif.redirect = 1'b1; fif.redirect_pc = 32'h0000_0043; fif.stall = 1'b1;
        fif.imemload = 32'h1111_1111;
        #1;
        chk("redir_ren", {31'd0, fif.imemREN}, 32'd0);
        step();
        chk("redir_addr", fif.imemaddr, 32'h40);
        chk("redir_valid", {31'd0, fif.ifid_valid}, 32'd0);
        chk("redir_count", fif.fetch_count, 32'd3);

        fif.redirect = 1'b0; fif.stall = 1'b0; fif.imemload = 32'hFFFF_FFFF;
        exp_q.push_back('{32'hFFFF_FFFF, 32'h40, 32'h44});
        step();

        // halt on the valid word; ihit in the same cycle must not be taken
        fif.halt_in = 1'b1; fif.imemload = 32'h0000_1234;
        step();
        fif.halt_in = 1'b0;
        chk("halt_flag", {31'd0, fif.halted}, 32'd1);
        chk("halt_ren", {31'd0, fif.imemREN}, 32'd0);
        chk("halt_addr", fif.imemaddr, 32'h44);
        chk("halt_count", fif.fetch_count, 32'd4);
        for (int i = 0; i < 3; i++) begin
            fif.redirect = (i % 2 == 0); fif.ihit = (i % 2 == 1);
            fif.redirect_pc = 32'h0000_0100;
            step();
            chk("halted_sticky", {31'd0, fif.halted}, 32'd1);
            chk("halted_ren", {31'd0, fif.imemREN}, 32'd0);
            chk("halted_addr", fif.imemaddr, 32'h44);
            chk("halted_ifid_pc", fif.ifid_pc, 32'h40);
        end
        fif.redirect = 1'b0; fif.ihit = 1'b0;

        fif.RST = 1'b1;
        step();
        fif.RST = 1'b0;
        chk("rst2_addr", fif.imemaddr, 32'h0);
        chk("rst2_halted", {31'd0, fif.halted}, 32'd0);
        chk("rst2_count", fif.fetch_count, 32'd0);
        chk("rst2_valid", {31'd0, fif.ifid_valid}, 32'd0);

        // PC wrap at top of address space
        fif.redirect = 1'b1; fif.redirect_pc = 32'hFFFF_FFFF;
        step();
        fif.redirect = 1'b0;
        chk("top_addr", fif.imemaddr, 32'hFFFF_FFFC);
        fif.ihit = 1'b1; fif.imemload = 32'h0000_000C;
        exp_q.push_back('{32'h0000_000C, 32'hFFFF_FFFC, 32'h0});
        step();
        chk("wrap_addr", fif.imemaddr, 32'h0);
        chk("wrap_npc", fif.ifid_npc, 32'h0);
        chk("wrap_count", fif.fetch_count, 32'd1);

        // flush discards ihit and holds PC
        fif.flush = 1'b1; fif.imemload = 32'h2222_2222;
        step();
        fif.flush = 1'b0; fif.ihit = 1'b0;
        chk("flush_valid", {31'd0, fif.ifid_valid}, 32'd0);
        chk("flush_addr", fif.imemaddr, 32'h0);
        chk("flush_count", fif.fetch_count, 32'd1);

        step();
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
